// File: rtl/br_pkg.sv
// Shared definitions for the branch resolution / prediction unit:
// branch opcode, condition codes and the BHT counter reset value.
package br_pkg;

  localparam logic [3:0] B_OP = 4'b1100;

  localparam logic [2:0] COND_NEQ    = 3'd0;
  localparam logic [2:0] COND_EQ     = 3'd1;
  localparam logic [2:0] COND_GT     = 3'd2;
  localparam logic [2:0] COND_LT     = 3'd3;
  localparam logic [2:0] COND_GTE    = 3'd4;
  localparam logic [2:0] COND_LTE    = 3'd5;
  localparam logic [2:0] COND_OVFL   = 3'd6;
  localparam logic [2:0] COND_UNCOND = 3'd7;

  // Weakly-not-taken: MSB clear, every lower bit set.
  function automatic logic [31:0] ctr_rst_val(input int ctr_w);
    return (32'd1 << (ctr_w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Combinational evaluation of a branch condition code against N/Z/V flags.
module br_cond_eval
  import br_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       n,
  input  logic       z,
  input  logic       v,
  output logic       cond_true
);

  // condition decode
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_NEQ:    cond_true = !z;
      COND_EQ:     cond_true = z;
      COND_GT:     cond_true = !z && !n;
      COND_LT:     cond_true = n;
      COND_GTE:    cond_true = !n;
      COND_LTE:    cond_true = n || z;
      COND_OVFL:   cond_true = v;
      COND_UNCOND: cond_true = 1'b1;
      default:     cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/br_pred_ctrl.sv
// Branch resolution and BHT prediction unit with bypassed flag register.
// Optional saturating branch statistics are built when BR_STATS_EN is defined.
module br_pred_ctrl
  import br_pkg::*;
#(
  parameter int PC_W      = 16,
  parameter int BHT_DEPTH = 16,
  parameter int CTR_W     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic [PC_W-1:0] if_pc,
  output logic            if_pred_taken,
  input  logic            ex_valid,
  input  logic [3:0]      ex_opcode,
  input  logic [2:0]      ex_br_cond,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_pred_taken,
  input  logic            flag_we,
  input  logic            flag_n,
  input  logic            flag_z,
  input  logic            flag_v,
  output logic [2:0]      flags_q,
  output logic            br_ctrl,
  output logic            mispredict,
  output logic [15:0]     stat_branches,
  output logic [15:0]     stat_mispred
);

  localparam int              IDX_W   = $clog2(BHT_DEPTH);
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(ctr_rst_val(CTR_W));
  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_MIN = {CTR_W{1'b0}};

  logic [2:0]       flags_r;
  logic [CTR_W-1:0] bht_r [BHT_DEPTH];
  logic [2:0]       eff_flags_s;
  logic             is_br_s;
  logic             cond_true_s;
  logic [IDX_W-1:0] ex_idx_s;
  logic [IDX_W-1:0] if_idx_s;
  logic [CTR_W-1:0] cur_ctr_s;
  logic [CTR_W-1:0] nxt_ctr_s;
  logic             unused_pc_s;

  assign ex_idx_s    = ex_pc[IDX_W-1:0];
  assign if_idx_s    = if_pc[IDX_W-1:0];
  assign unused_pc_s = ^{if_pc[PC_W-1:IDX_W], ex_pc[PC_W-1:IDX_W]};

  // Incoming ALU flags win over the register so a flag-setting op feeds a branch in the same cycle.
  assign eff_flags_s = flag_we ? {flag_n, flag_z, flag_v} : flags_r;
  assign is_br_s     = ex_valid && (ex_opcode == B_OP);

  br_cond_eval u_cond (
    .cond      (ex_br_cond),
    .n         (eff_flags_s[2]),
    .z         (eff_flags_s[1]),
    .v         (eff_flags_s[0]),
    .cond_true (cond_true_s)
  );

  assign br_ctrl       = is_br_s && cond_true_s;
  assign mispredict    = ex_valid && (br_ctrl != ex_pred_taken);
  assign if_pred_taken = bht_r[if_idx_s][CTR_W-1];
  assign flags_q       = flags_r;
  assign cur_ctr_s     = bht_r[ex_idx_s];

  // saturating counter step for the resolving branch
  always_comb begin
    nxt_ctr_s = cur_ctr_s;
    if (br_ctrl) begin
      if (cur_ctr_s != CTR_MAX) nxt_ctr_s = cur_ctr_s + CTR_W'(1);
      else                      nxt_ctr_s = cur_ctr_s;
    end else begin
      if (cur_ctr_s != CTR_MIN) nxt_ctr_s = cur_ctr_s - CTR_W'(1);
      else                      nxt_ctr_s = cur_ctr_s;
    end
  end

  // flag register and BHT state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r <= 3'b000;
      for (int i = 0; i < BHT_DEPTH; i++) bht_r[i] <= CTR_RST;
    end else if (!stall) begin
      if (flag_we) flags_r <= {flag_n, flag_z, flag_v};
      if (is_br_s) bht_r[ex_idx_s] <= nxt_ctr_s;
    end
  end

`ifdef BR_STATS_EN
  logic [15:0] stat_br_r;
  logic [15:0] stat_mis_r;

  // resolved-branch and mispredict counters, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_r  <= 16'h0000;
      stat_mis_r <= 16'h0000;
    end else if (!stall && is_br_s) begin
      if (stat_br_r != 16'hFFFF) stat_br_r <= stat_br_r + 16'd1;
      if (mispredict && (stat_mis_r != 16'hFFFF)) stat_mis_r <= stat_mis_r + 16'd1;
    end
  end

  assign stat_branches = stat_br_r;
  assign stat_mispred  = stat_mis_r;
`else
  assign stat_branches = 16'h0000;
  assign stat_mispred  = 16'h0000;
`endif

endmodule

// File: tb/tb_br_pred_ctrl.sv
// Directed self-checking bench for br_pred_ctrl: condition table plus
// multi-cycle sequences for bypass, BHT training, stall, reset and stats.
module tb_br_pred_ctrl;
  import br_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [15:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [2:0]  ex_br_cond;
  logic [15:0] ex_pc;
  logic        ex_pred_taken;
  logic        flag_we, flag_n, flag_z, flag_v;
  logic [2:0]  flags_q;
  logic        br_ctrl, mispredict;
  logic [15:0] stat_branches, stat_mispred;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0] op;
    logic       valid;
    logic [2:0] cond;
    logic       n, z, v, pred, exp_br, exp_mis;
  } vec_t;

  vec_t vecs [17];

  br_pred_ctrl dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_br_cond(ex_br_cond),
    .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
    .flag_we(flag_we), .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v),
    .flags_q(flags_q), .br_ctrl(br_ctrl), .mispredict(mispredict),
    .stat_branches(stat_branches), .stat_mispred(stat_mispred)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ex(input logic valid, input logic [3:0] op, input logic [2:0] cond,
                        input logic [15:0] pc, input logic pred);
    ex_valid      = valid;
    ex_opcode     = op;
    ex_br_cond    = cond;
    ex_pc         = pc;
    ex_pred_taken = pred;
  endtask

  task automatic set_flags(input logic we, input logic n, input logic z, input logic v);
    flag_we = we;
    flag_n  = n;
    flag_z  = z;
    flag_v  = v;
  endtask

  initial begin
    logic [15:0] exp_b3, exp_m3, exp_sat;
`ifdef BR_STATS_EN
    exp_b3 = 16'd3; exp_m3 = 16'd2; exp_sat = 16'hFFFF;
`else
    exp_b3 = 16'd0; exp_m3 = 16'd0; exp_sat = 16'h0000;
`endif

    vecs[0]  = '{B_OP, 1'b1, COND_NEQ,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{B_OP, 1'b1, COND_EQ,     1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{B_OP, 1'b1, COND_GT,     1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{B_OP, 1'b1, COND_LT,     1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{B_OP, 1'b1, COND_GTE,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{B_OP, 1'b1, COND_LTE,    1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{B_OP, 1'b1, COND_OVFL,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{B_OP, 1'b1, COND_UNCOND, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{B_OP, 1'b1, COND_NEQ,    1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{B_OP, 1'b1, COND_GT,     1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{B_OP, 1'b1, COND_LT,     1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{B_OP, 1'b1, COND_GTE,    1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{B_OP, 1'b1, COND_LTE,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{B_OP, 1'b1, COND_OVFL,   1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{B_OP, 1'b0, COND_UNCOND, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{4'h3, 1'b1, COND_UNCOND, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{4'h3, 1'b1, COND_UNCOND, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // reset
    rst_n = 1'b0; stall = 1'b0; if_pc = 16'd0;
    set_ex(1'b0, 4'h0, 3'd0, 16'd0, 1'b0);
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #2;
    chk("reset flags_q", 32'(flags_q), 32'h0);
    chk("reset stat_branches", 32'(stat_branches), 32'h0);
    chk("reset stat_mispred", 32'(stat_mispred), 32'h0);
    chk("reset br_ctrl", 32'(br_ctrl), 32'h0);
    chk("reset mispredict", 32'(mispredict), 32'h0);
    for (int i = 0; i < 16; i++) begin
      if_pc = 16'(i);
      #1 chk($sformatf("reset pred idx%0d", i), 32'(if_pred_taken), 32'h0);
    end

    // flag bypass into a same-cycle eq branch
    @(negedge clk);
    set_flags(1'b1, 1'b0, 1'b1, 1'b0);
    set_ex(1'b1, B_OP, COND_EQ, 16'd3, 1'b0);
    #2;
    chk("bypass br_ctrl", 32'(br_ctrl), 32'h1);
    chk("bypass mispredict", 32'(mispredict), 32'h1);
    @(posedge clk) #1;
    chk("bypass flags_q", 32'(flags_q), 32'h2);

    // BHT training at pc 7: taken x3, not-taken, non-branch, not-taken
    @(negedge clk);
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    if_pc = 16'd7;
    set_ex(1'b1, B_OP, COND_UNCOND, 16'd7, 1'b0);
    #2 chk("train pred upd0", 32'(if_pred_taken), 32'h0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk) #1;
      chk($sformatf("train pred upd%0d", k), 32'(if_pred_taken), 32'h1);
    end
    @(negedge clk) set_ex(1'b1, B_OP, COND_NEQ, 16'd7, 1'b0);
    #2 chk("nottaken br_ctrl", 32'(br_ctrl), 32'h0);
    chk("nottaken mispredict", 32'(mispredict), 32'h0);
    @(posedge clk) #1 chk("train pred upd4", 32'(if_pred_taken), 32'h1);
    @(negedge clk) set_ex(1'b1, 4'h0, COND_UNCOND, 16'd7, 1'b1);
    #2 chk("nonbr br_ctrl", 32'(br_ctrl), 32'h0);
    chk("nonbr mispredict", 32'(mispredict), 32'h1);
    @(posedge clk) #1 chk("nonbr no bht write", 32'(if_pred_taken), 32'h1);
    @(negedge clk) set_ex(1'b1, B_OP, COND_NEQ, 16'd7, 1'b0);
    @(posedge clk) #1 chk("train pred upd5", 32'(if_pred_taken), 32'h0);

    // condition table, stalled so no state moves
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      stall = 1'b1;
      set_flags(1'b1, vecs[i].n, vecs[i].z, vecs[i].v);
      set_ex(vecs[i].valid, vecs[i].op, vecs[i].cond, 16'd7, vecs[i].pred);
      #2;
      chk($sformatf("vec%0d br_ctrl", i), 32'(br_ctrl), 32'(vecs[i].exp_br));
      chk($sformatf("vec%0d mispredict", i), 32'(mispredict), 32'(vecs[i].exp_mis));
    end
    @(posedge clk) #1;
    chk("table stall flags_q", 32'(flags_q), 32'h2);
    chk("table stall bht7", 32'(if_pred_taken), 32'h0);

    // stalled taken branch at pc 5, then release
    @(negedge clk);
    stall = 1'b1; if_pc = 16'd5;
    set_flags(1'b1, 1'b1, 1'b1, 1'b1);
    set_ex(1'b1, B_OP, COND_UNCOND, 16'd5, 1'b0);
    #2 chk("stall br_ctrl", 32'(br_ctrl), 32'h1);
    @(posedge clk) #1;
    chk("stall bht5", 32'(if_pred_taken), 32'h0);
    chk("stall flags_q", 32'(flags_q), 32'h2);
    @(negedge clk) stall = 1'b0;
    @(posedge clk) #1;
    chk("unstall bht5", 32'(if_pred_taken), 32'h1);
    chk("unstall flags_q", 32'(flags_q), 32'h7);

    // asynchronous reset mid-cycle
    @(negedge clk);
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    set_ex(1'b0, 4'h0, 3'd0, 16'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("midrst flags_q", 32'(flags_q), 32'h0);
    chk("midrst bht5", 32'(if_pred_taken), 32'h0);
    chk("midrst stat_branches", 32'(stat_branches), 32'h0);
    if_pc = 16'd3;
    #1 chk("midrst bht3", 32'(if_pred_taken), 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // stats: 3 counted branches (2 mispredicted), plus uncounted activity
    @(negedge clk) set_ex(1'b1, B_OP, COND_UNCOND, 16'd0, 1'b0);
    @(negedge clk) set_ex(1'b1, B_OP, COND_UNCOND, 16'd0, 1'b1);
    @(negedge clk) set_ex(1'b1, B_OP, COND_NEQ, 16'd0, 1'b0);
    @(negedge clk) set_ex(1'b1, 4'h0, COND_UNCOND, 16'd0, 1'b1);
    @(negedge clk) set_ex(1'b0, B_OP, COND_UNCOND, 16'd0, 1'b0);
    @(negedge clk) begin
      stall = 1'b1;
      set_ex(1'b1, B_OP, COND_UNCOND, 16'd0, 1'b0);
    end
    @(negedge clk) begin
      stall = 1'b0;
      set_ex(1'b0, 4'h0, 3'd0, 16'd0, 1'b0);
    end
    chk("stat_branches small", 32'(stat_branches), 32'(exp_b3));
    chk("stat_mispred small", 32'(stat_mispred), 32'(exp_m3));

    // saturation
    set_ex(1'b1, B_OP, COND_UNCOND, 16'd0, 1'b0);
    repeat (70000) @(posedge clk);
    @(negedge clk) set_ex(1'b0, 4'h0, 3'd0, 16'd0, 1'b0);
    chk("stat_branches sat", 32'(stat_branches), 32'(exp_sat));
    chk("stat_mispred sat", 32'(stat_mispred), 32'(exp_sat));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
